y86_mem_responder: RTL

//  Memory-side end of the Y86-64 core's instruction and data ports: unified byte-addressed, little-endian RAM.

---
 rtl/y86_pkg.sv | 14 +
 rtl/y86_mem_responder_if.sv | 33 +++
 rtl/y86_mem_lane_extract.sv | 15 +
 rtl/y86_mem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared width constants and loader state encoding for the Y86-64 memory responder.
package y86_pkg;

    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 64;
    localparam int PC_WIDTH       = 80;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } ld_state_t;

endpackage

// File: rtl/y86_mem_responder_if.sv
// Core fetch/data ports plus host loader stream between the Y86-64 core side and the memory responder.
interface y86_mem_responder_if;
    import y86_pkg::*;

    logic [MEM_ADDR_WIDTH-1:0] instr_addr;
    logic [PC_WIDTH-1:0]       instr_din;
    logic                      imem_ok;
    logic [MEM_ADDR_WIDTH-1:0] data_addr;
    logic [MEM_DATA_WIDTH-1:0] data_din;
    logic [MEM_DATA_WIDTH-1:0] data_dout;
    logic                      data_we;
    logic                      data_re;
    logic                      dmem_ok;
    logic                      ld_valid;
    logic [7:0]                ld_byte;
    logic                      ld_last;
    logic                      ld_ready;
    logic                      ld_err;
    logic                      cpu_rst_n;

    modport master (
        output instr_addr, data_addr, data_dout, data_we, data_re,
               ld_valid, ld_byte, ld_last,
        input  instr_din, imem_ok, data_din, dmem_ok, ld_ready, ld_err, cpu_rst_n
    );

    modport slave (
        input  instr_addr, data_addr, data_dout, data_we, data_re,
               ld_valid, ld_byte, ld_last,
        output instr_din, imem_ok, data_din, dmem_ok, ld_ready, ld_err, cpu_rst_n
    );

endinterface

// File: rtl/y86_mem_lane_extract.sv
// Combinational byte-offset window: shifts N little-endian words right by offset bytes and keeps OUT_WIDTH bits.
module y86_mem_lane_extract
    import y86_pkg::*;
#(
    parameter int N_WORDS   = 2,
    parameter int OUT_WIDTH = 64
) (
    input  logic [N_WORDS*MEM_DATA_WIDTH-1:0] words,
    input  logic [2:0]                        offset,
    output logic [OUT_WIDTH-1:0]              window
);

    assign window = OUT_WIDTH'(words >> {offset, 3'b000});

endmodule

// File: rtl/y86_mem_responder.sv
// Unified byte-addressed little-endian RAM for the Y86-64 core with a clear/load/run bring-up FSM.
// Define Y86_MEM_ALIGN_CHECK_EN to reject unaligned data accesses instead of merging two words.
//
// state    | meaning
// ST_CLEAR | zero one word per cycle, core held in reset
// ST_LOAD  | accept host bytes at LOAD_BASE+cnt until ld_last
// ST_RUN   | core released, fetch/data ports live
module y86_mem_responder
    import y86_pkg::*;
#(
    parameter int unsigned               DEPTH_WORDS = 1024,
    parameter logic [MEM_ADDR_WIDTH-1:0] LOAD_BASE   = '0
) (
    input logic               clk,
    input logic               rst,
    y86_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int A1 = MEM_ADDR_WIDTH + 1;
    localparam logic [A1-1:0] CAP_BYTES = A1'(DEPTH_WORDS) << 3;

    logic [MEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    ld_state_t   state;
    logic [31:0] cnt;
    logic        ld_ready_q;
    logic        ld_err_q;
    logic        cpu_rst_n_q;
    logic        run;

    assign run           = (state == ST_RUN);
    assign bus.ld_ready  = ld_ready_q;
    assign bus.ld_err    = ld_err_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;

    // Fetch: range sums are one bit wider so an address near 2^64 cannot wrap into range.
    logic [A1-1:0]       f_end;
    logic [AW-1:0]       fw0, fw1, fw2;
    logic [PC_WIDTH-1:0] fetch_win;

    assign f_end = {1'b0, bus.instr_addr} + A1'(9);
    assign fw0   = bus.instr_addr[AW+2:3];
    assign fw1   = fw0 + AW'(1);
    assign fw2   = fw0 + AW'(2);

    y86_mem_lane_extract #(.N_WORDS(3), .OUT_WIDTH(PC_WIDTH)) u_fetch (
        .words  ({mem[fw2], mem[fw1], mem[fw0]}),
        .offset (bus.instr_addr[2:0]),
        .window (fetch_win)
    );

    assign bus.imem_ok   = run && (f_end < CAP_BYTES);
    assign bus.instr_din = bus.imem_ok ? fetch_win : '0;

    logic [A1-1:0]             d_end;
    logic [AW-1:0]             dw0, dw1;
    logic                      d_legal;
    logic                      wr_en;
    logic [MEM_DATA_WIDTH-1:0] data_rd, wr_lo, wr_hi;
    logic                      wr_hi_en;

    assign d_end = {1'b0, bus.data_addr} + A1'(7);
    assign dw0   = bus.data_addr[AW+2:3];
    assign dw1   = dw0 + AW'(1);

`ifdef Y86_MEM_ALIGN_CHECK_EN
    assign d_legal  = run && (d_end < CAP_BYTES) && (bus.data_addr[2:0] == 3'b000);
    assign data_rd  = mem[dw0];
    assign wr_lo    = bus.data_dout;
    assign wr_hi    = '0;
    assign wr_hi_en = 1'b0;
`else
    logic [2*MEM_DATA_WIDTH-1:0] d_old, d_mask, d_new;

    assign d_legal = run && (d_end < CAP_BYTES);
    assign d_old   = {mem[dw1], mem[dw0]};

    y86_mem_lane_extract #(.N_WORDS(2), .OUT_WIDTH(MEM_DATA_WIDTH)) u_data (
        .words  (d_old),
        .offset (bus.data_addr[2:0]),
        .window (data_rd)
    );

    assign d_mask   = {{MEM_DATA_WIDTH{1'b0}}, {MEM_DATA_WIDTH{1'b1}}} << {bus.data_addr[2:0], 3'b000};
    assign d_new    = (d_old & ~d_mask)
                    | ({{MEM_DATA_WIDTH{1'b0}}, bus.data_dout} << {bus.data_addr[2:0], 3'b000});
    assign wr_lo    = d_new[MEM_DATA_WIDTH-1:0];
    assign wr_hi    = d_new[2*MEM_DATA_WIDTH-1:MEM_DATA_WIDTH];
    assign wr_hi_en = (bus.data_addr[2:0] != 3'b000);
`endif

    // An idle data port reports ok only once running, so dmem_ok stays low through bring-up.
    assign bus.dmem_ok  = run && ((!bus.data_we && !bus.data_re) || d_legal);
    assign bus.data_din = d_legal ? data_rd : '0;
    assign wr_en        = bus.data_we && d_legal;

    logic [A1-1:0] ld_addr;
    logic          ld_in;
    logic          ld_fire;

    assign ld_addr = {1'b0, LOAD_BASE} + A1'(cnt);
    assign ld_in   = (ld_addr < CAP_BYTES);
    assign ld_fire = bus.ld_valid && ld_ready_q && (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state)
                ST_CLEAR: mem[cnt[AW-1:0]] <= '0;
                ST_LOAD: begin
                    if (ld_fire && ld_in)
                        mem[ld_addr[AW+2:3]][{ld_addr[2:0], 3'b000} +: 8] <= bus.ld_byte;
                end
                ST_RUN: begin
                    if (wr_en) begin
                        mem[dw0] <= wr_lo;
                        if (wr_hi_en)
                            mem[dw1] <= wr_hi;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            ld_ready_q  <= 1'b0;
            ld_err_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == 32'(DEPTH_WORDS - 1)) begin
                        state      <= ST_LOAD;
                        cnt        <= '0;
                        ld_ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        cnt <= cnt + 32'd1;
                        if (!ld_in)
                            ld_err_q <= 1'b1;
                        if (bus.ld_last) begin
                            state      <= ST_RUN;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                ST_RUN:  cpu_rst_n_q <= 1'b1;
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule
